// File: rtl/wave_seq_ctrl.sv
// wave_seq_ctrl -- note sequencer for the waveform generator.
//
// A host pushes notes (freq, wave, duty, duration) into a DEPTH-entry FIFO over
// a valid/ready handshake. Notes play one after another. Each note lasts
// note_dur ticks of TICK_DIV clk cycles. gen_en gates the generator while a
// note is playing and run=1.
//
// Optional build macro: WSEQ_GAP_EN. It inserts GAP_TICKS silent ticks after
// every note, counted by the same prescaler and paused by run=0.
//
// Ports:
//   clk, rst                        clock, synchronous active-high reset
//   note_valid / note_ready         host push handshake
//   note_freq/wave/duty/dur         note fields (dur==0 -> note is discarded)
//   run                             1 plays, 0 pauses
//   flush                           abort playback and empty the FIFO
//   freq_out/wave_sel_out/duty_out  latched generator configuration
//   gen_en                          generator enable
//   note_done                       1-cycle pulse per finished/discarded note
//   busy, fifo_count                status
module wave_seq_ctrl #(
  parameter int WIDTH     = 16,
  parameter int CNT_WIDTH = 16,
  parameter int DUR_WIDTH = 12,
  parameter int DEPTH     = 4,
  parameter int TICK_DIV  = 48000,
  parameter int GAP_TICKS = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   note_valid,
  output logic                   note_ready,
  input  logic [WIDTH-1:0]       note_freq,
  input  logic [1:0]             note_wave,
  input  logic [CNT_WIDTH-1:0]   note_duty,
  input  logic [DUR_WIDTH-1:0]   note_dur,
  input  logic                   run,
  input  logic                   flush,
  output logic [WIDTH-1:0]       freq_out,
  output logic [1:0]             wave_sel_out,
  output logic [CNT_WIDTH-1:0]   duty_out,
  output logic                   gen_en,
  output logic                   note_done,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] fifo_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = $clog2(TICK_DIV);
  localparam int GW = $clog2(GAP_TICKS + 1);
  // The duration counter doubles as the gap counter, so it must hold both.
  localparam int CW = (DUR_WIDTH > GW) ? DUR_WIDTH : GW;

  typedef struct packed {
    logic [WIDTH-1:0]     freq;
    logic [1:0]           wave;
    logic [CNT_WIDTH-1:0] duty;
    logic [DUR_WIDTH-1:0] dur;
  } note_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_PLAY,
`ifdef WSEQ_GAP_EN
    S_GAP,
`endif
    S_DONE
  } state_t;

  state_t               state_q, state_d;
  note_t                mem_q [DEPTH];
  note_t                mem_d [DEPTH];
  logic [AW-1:0]        wr_q, wr_d, rd_q, rd_d;
  logic [AW:0]          cnt_q, cnt_d;
  logic [PW-1:0]        presc_q, presc_d;
  logic [CW-1:0]        dur_q, dur_d;
  logic [WIDTH-1:0]     freq_q, freq_d;
  logic [1:0]           wave_q, wave_d;
  logic [CNT_WIDTH-1:0] duty_q, duty_d;

  logic  full, push, pop, tick, more;
  note_t head;

  assign full       = (cnt_q == (AW+1)'(DEPTH));
  assign note_ready = !rst && !full && !flush;
  assign push       = note_valid && note_ready;
  assign pop        = (state_q == S_LOAD);
  assign head       = mem_q[rd_q];
  assign tick       = run && (presc_q == PW'(TICK_DIV - 1));
  assign more       = (cnt_q != '0) && run;

  assign freq_out     = freq_q;
  assign wave_sel_out = wave_q;
  assign duty_out     = duty_q;
  assign gen_en       = (state_q == S_PLAY) && run;
  assign note_done    = (state_q == S_DONE);
  assign busy         = (state_q != S_IDLE) || (cnt_q != '0);
  assign fifo_count   = cnt_q;

  always_comb begin
    state_d = state_q;
    mem_d   = mem_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    cnt_d   = cnt_q;
    presc_d = presc_q;
    dur_d   = dur_q;
    freq_d  = freq_q;
    wave_d  = wave_q;
    duty_d  = duty_q;

    if (flush) begin
      // Generator config holds; only sequencing state is cleared.
      state_d = S_IDLE;
      wr_d    = '0;
      rd_d    = '0;
      cnt_d   = '0;
      presc_d = '0;
      dur_d   = '0;
    end else begin
      if (push) begin
        mem_d[wr_q] = {note_freq, note_wave, note_duty, note_dur};
        wr_d        = wr_q + AW'(1);
      end
      if (pop) rd_d = rd_q + AW'(1);
      case ({push, pop})
        2'b10:   cnt_d = cnt_q + (AW+1)'(1);
        2'b01:   cnt_d = cnt_q - (AW+1)'(1);
        default: cnt_d = cnt_q;
      endcase

      case (state_q)
        S_IDLE: if (more) state_d = S_LOAD;
        S_LOAD: begin
          if (head.dur == '0) begin
            state_d = S_DONE;
          end else begin
            freq_d  = head.freq;
            wave_d  = (head.wave == 2'b11) ? 2'b00 : head.wave;
            duty_d  = head.duty;
            dur_d   = CW'(head.dur);
            presc_d = '0;
            state_d = S_PLAY;
          end
        end
        S_PLAY: begin
          if (tick) begin
            presc_d = '0;
            dur_d   = dur_q - CW'(1);
            if (dur_q == CW'(1)) state_d = S_DONE;
          end else if (run) begin
            presc_d = presc_q + PW'(1);
          end
        end
`ifdef WSEQ_GAP_EN
        S_DONE: begin
          presc_d = '0;
          dur_d   = CW'(GAP_TICKS);
          state_d = S_GAP;
        end
        S_GAP: begin
          if (tick) begin
            presc_d = '0;
            dur_d   = dur_q - CW'(1);
            if (dur_q == CW'(1)) state_d = more ? S_LOAD : S_IDLE;
          end else if (run) begin
            presc_d = presc_q + PW'(1);
          end
        end
`else
        S_DONE: state_d = more ? S_LOAD : S_IDLE;
`endif
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
      presc_q <= '0;
      dur_q   <= '0;
      freq_q  <= '0;
      wave_q  <= '0;
      duty_q  <= '0;
    end else begin
      state_q <= state_d;
      mem_q   <= mem_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      cnt_q   <= cnt_d;
      presc_q <= presc_d;
      dur_q   <= dur_d;
      freq_q  <= freq_d;
      wave_q  <= wave_d;
      duty_q  <= duty_d;
    end
  end

endmodule

// File: tb/tb_wave_seq_ctrl.sv
// Testbench for wave_seq_ctrl: directed scenarios plus randomized traffic.
// A scoreboard queue holds accepted notes. A negedge monitor checks each
// note_done and each gen_en start against the head of that queue.
module tb_wave_seq_ctrl;
  localparam int W = 16, CWD = 16, DW = 12, DEPTH = 4, TD = 4, GT = 2;
`ifdef WSEQ_GAP_EN
  localparam int EXPG = 2 + GT * TD;
`else
  localparam int EXPG = 2;
`endif

  logic clk = 1'b0;
  logic rst, note_valid, note_ready, run, flush, gen_en, note_done, busy;
  logic [W-1:0]   note_freq, freq_out;
  logic [1:0]     note_wave, wave_sel_out;
  logic [CWD-1:0] note_duty, duty_out;
  logic [DW-1:0]  note_dur;
  logic [$clog2(DEPTH):0] fifo_count;

  always #5 clk = ~clk;

  wave_seq_ctrl #(.WIDTH(W), .CNT_WIDTH(CWD), .DUR_WIDTH(DW), .DEPTH(DEPTH),
                  .TICK_DIV(TD), .GAP_TICKS(GT)) dut (
    .clk(clk), .rst(rst), .note_valid(note_valid), .note_ready(note_ready),
    .note_freq(note_freq), .note_wave(note_wave), .note_duty(note_duty),
    .note_dur(note_dur), .run(run), .flush(flush), .freq_out(freq_out),
    .wave_sel_out(wave_sel_out), .duty_out(duty_out), .gen_en(gen_en),
    .note_done(note_done), .busy(busy), .fifo_count(fifo_count));

  typedef struct packed {
    logic [W-1:0]   f;
    logic [1:0]     w;
    logic [CWD-1:0] d;
    logic [DW-1:0]  dur;
  } note_t;

  note_t sb[$];
  int    low_runs[$];
  int    tests = 0, fails = 0;
  int    hi_cnt = 0, low_cnt = 0;
  logic  gen_prev = 1'b0;
  logic [W-1:0]   ef = '0;
  logic [1:0]     ew = '0;
  logic [CWD-1:0] ed = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [1:0] mapw(input logic [1:0] w);
    return (w == 2'd3) ? 2'd0 : w;
  endfunction

  // Monitor: a played note must show its config when gen_en starts, and at
  // note_done must have had exactly dur*TD enabled cycles.
  always @(negedge clk) begin
    note_t n;
    if (gen_en === 1'b1) begin
      if (!gen_prev) begin
        low_runs.push_back(low_cnt);
        if (sb.size() == 0) chk("gen_en_without_note", 1, 0);
        else begin
          chk("start_freq", freq_out, sb[0].f);
          chk("start_wave", wave_sel_out, mapw(sb[0].w));
          chk("start_duty", duty_out, sb[0].d);
        end
      end
      hi_cnt++;
      low_cnt = 0;
    end else begin
      low_cnt++;
    end
    gen_prev = (gen_en === 1'b1);
    if (note_done === 1'b1) begin
      if (sb.size() == 0) chk("unexpected_note_done", 1, 0);
      else begin
        n = sb.pop_front();
        if (n.dur != 0) begin ef = n.f; ew = mapw(n.w); ed = n.d; end
        chk("gen_en_cycles", hi_cnt, n.dur * TD);
        chk("done_freq", freq_out, ef);
        chk("done_wave", wave_sel_out, ew);
        chk("done_duty", duty_out, ed);
      end
      hi_cnt = 0;
    end
    if (rst === 1'b1) begin
      sb.delete(); hi_cnt = 0; ef = '0; ew = '0; ed = '0;
    end else if (flush === 1'b1) begin
      sb.delete(); hi_cnt = 0;
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Offer a note and hold it until accepted; returns cycles spent not ready.
  task automatic send(input note_t n, input int lim, output int waits);
    note_freq = n.f; note_wave = n.w; note_duty = n.d; note_dur = n.dur;
    note_valid = 1'b1;
    waits = 0;
    forever begin
      @(negedge clk);
      if (note_ready === 1'b1) begin sb.push_back(n); break; end
      waits++;
      if (waits == 4 && lim > 10) run = 1'b1;
      if (waits >= lim) begin chk("push_timeout", 0, 1); break; end
    end
    @(posedge clk); #1;
    note_valid = 1'b0;
  endtask

  task automatic wait_idle(input int lim);
    int n = 0;
    do begin @(negedge clk); n++; end while (busy !== 1'b0 && n < lim);
    chk("idle_reached", busy, 0);
    chk("sb_drained", sb.size(), 0);
    step(1);
  endtask

  task automatic wait_gen(input int lim);
    int n = 0;
    do begin @(negedge clk); n++; end while (gen_en !== 1'b1 && n < lim);
    chk("gen_en_seen", gen_en, 1);
  endtask

  function automatic note_t mk(input int f, input int w, input int d, input int dur);
    note_t n;
    n.f = W'(f); n.w = 2'(w); n.d = CWD'(d); n.dur = DW'(dur);
    return n;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w, bad;
    rst = 1; note_valid = 0; run = 0; flush = 0;
    note_freq = '0; note_wave = '0; note_duty = '0; note_dur = '0;

    // 1. reset
    step(2);
    chk("rst_note_ready_low", note_ready, 0);
    rst = 0; #1;
    chk("reset_outputs", {freq_out, wave_sel_out, duty_out, gen_en, note_done}, 0);
    chk("reset_note_ready", note_ready, 1);
    chk("reset_busy", busy, 0);
    chk("reset_fifo_count", fifo_count, 0);

    // 2. single note with exact start latency
    run = 1;
    send(mk(16'h0100, 1, 16'h0008, 3), 20, w);
    @(negedge clk); chk("lat_after_e0", gen_en, 0);
    @(negedge clk); chk("lat_after_e1", gen_en, 0);
    @(negedge clk); chk("lat_after_e2", gen_en, 1);
    chk("single_freq", freq_out, 16'h0100);
    wait_idle(100);

    // 3. full FIFO, then play in order
    run = 0;
    for (int i = 0; i < 4; i++) send(mk(i + 1, i % 3, 10 * i, 1 + i % 2), 20, w);
    @(negedge clk);
    chk("full_fifo_count", fifo_count, 4);
    chk("full_note_ready", note_ready, 0);
    chk("full_busy", busy, 1);
    step(1);
    low_runs.delete();
    run = 1;
    send(mk(5, 2, 50, 1), 50, w);
    chk("fifth_accept_wait", w, 2);
    wait_idle(300);
    chk("rise_count", low_runs.size(), 5);
    for (int i = 1; i < 5 && i < low_runs.size(); i++) chk("inter_note_gap", low_runs[i], EXPG);

    // 4. dur=0 discarded between dur=2 notes; wave 11 latched as 00
    run = 0;
    send(mk(16'h0AAA, 2, 3, 2), 20, w);
    send(mk(16'h0BBB, 1, 4, 0), 20, w);
    send(mk(16'h0CCC, 3, 5, 2), 20, w);
    run = 1;
    wait_idle(200);
    chk("wave11_as_00", wave_sel_out, 0);
    chk("last_freq", freq_out, 16'h0CCC);

    // 5. pause mid-PLAY
    send(mk(16'h0321, 0, 7, 3), 20, w);
    wait_gen(20);
    step(3);
    run = 0; bad = 0;
    repeat (10) begin @(negedge clk); if (gen_en !== 1'b0) bad++; end
    chk("pause_gen_en_low", bad, 0);
    chk("pause_busy", busy, 1);
    step(1); run = 1;
    wait_idle(200);

    // 6a. flush mid-PLAY with two notes queued
    run = 0;
    send(mk(16'h1234, 1, 9, 3), 20, w);
    send(mk(16'h2345, 2, 9, 3), 20, w);
    send(mk(16'h3456, 0, 9, 3), 20, w);
    run = 1;
    wait_gen(20);
    step(2);
    flush = 1; #1;
    chk("flush_note_ready", note_ready, 0);
    step(1); flush = 0; #1;
    chk("flush_gen_en", gen_en, 0);
    chk("flush_fifo_count", fifo_count, 0);
    chk("flush_busy", busy, 0);
    chk("flush_hold_freq", freq_out, 16'h1234);
    bad = 0;
    repeat (12) begin @(negedge clk); if (note_done !== 1'b0) bad++; end
    chk("flush_no_note_done", bad, 0);
    step(1);

    // 6b. reset mid-PLAY
    send(mk(16'h4567, 2, 11, 3), 20, w);
    wait_gen(20);
    step(1);
    rst = 1;
    step(1);
    chk("rst_mid_outputs", {freq_out, wave_sel_out, duty_out, gen_en, note_done, busy}, 0);
    chk("rst_mid_fifo_count", fifo_count, 0);
    rst = 0; #1;
    chk("rst_mid_note_ready", note_ready, 1);

    // randomized traffic with run toggling
    for (int i = 0; i < 40; i++) begin
      run = ($urandom_range(0, 3) != 0);
      step($urandom_range(0, 3));
      send(mk($urandom, $urandom, $urandom, $urandom_range(0, 3)), 100, w);
    end
    run = 1;
    wait_idle(2000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/wave_seq_ctrl.md
Name: wave_seq_ctrl

Overview:
Note sequencer that drives the waveform generator's configuration inputs: frequency select, wave select and duty cycle. A host pushes notes (frequency, wave, duty, duration) into a small internal FIFO over a valid/ready handshake. The block plays the notes one after another, each for a programmed number of duration ticks, and gates the generator with gen_en. It sits between the MP3-player control logic and the wave generator.

Parameters:
WIDTH, 16, frequency-select width; must match the generator's freq_in.
CNT_WIDTH, 16, duty-cycle width; must match the generator's duty_cyc.
DUR_WIDTH, 12, note duration width, in ticks.
DEPTH, 4, note FIFO depth; power of 2, at least 2.
TICK_DIV, 48000, clk cycles per duration tick; at least 2.
GAP_TICKS, 1, silent ticks between notes; used only with WSEQ_GAP_EN; at least 1.

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
note_valid  in  1  host offers a note
note_ready  out  1  FIFO can accept a note
note_freq  in  WIDTH  frequency select for the note
note_wave  in  2  00 sine, 01 rectangular, 10 sawtooth, 11 reserved
note_duty  in  CNT_WIDTH  duty cycle (rectangular wave)
note_dur  in  DUR_WIDTH  duration in ticks; 0 means discard
run  in  1  1 plays; 0 pauses
flush  in  1  abort playback and empty the FIFO
freq_out  out  WIDTH  to generator freq_in
wave_sel_out  out  2  to generator wave select
duty_out  out  CNT_WIDTH  to generator duty_cyc
gen_en  out  1  generator output enable (mute when 0)
note_done  out  1  one-cycle pulse at the end or discard of each note
busy  out  1  state is not IDLE, or fifo_count is not 0
fifo_count  out  $clog2(DEPTH)+1  notes queued

Behaviour:
- Reset (rst=1 at a clk edge):
  - state=IDLE; FIFO empty; prescaler=0; duration counter=0.
  - All outputs 0, except note_ready=1 once rst is low.
- FIFO:
  - Push when note_valid && note_ready.
  - note_ready = !full && !flush.
  - Pop happens only in LOAD.
  - Push and pop in the same cycle: fifo_count unchanged, order preserved.
  - Pushes while full are impossible; the host holds note_valid.
- flush:
  - Priority is below rst and above everything else.
  - At the next edge: FIFO emptied, state=IDLE, prescaler and duration counter cleared.
  - gen_en is 0 from that edge on.
  - freq_out, wave_sel_out and duty_out hold their values.
  - No note_done pulse.
- FSM, registered, states IDLE, LOAD, PLAY, DONE:
  - IDLE: if fifo_count!=0 && run, go to LOAD.
  - LOAD (1 cycle): pop the head entry.
    - If note_dur==0: go to DONE; outputs unchanged.
    - Otherwise: latch freq_out, duty_out and wave_sel_out (note_wave 11 is latched as 00); load the duration counter with note_dur; clear the prescaler; go to PLAY.
  - PLAY:
    - While run=1: prescaler counts 0..TICK_DIV-1 and wraps.
    - On a wrap, the duration counter decrements.
    - On a wrap with counter==1: go to DONE.
    - While run=0: prescaler and counter are frozen.
  - DONE (1 cycle): note_done=1. Go to LOAD if fifo_count!=0 && run, else IDLE.
- gen_en = (state==PLAY) && run. It is derived combinationally from registered state and the run input.
- Timing:
  - A push accepted at edge E0 into an empty FIFO, with state IDLE and run=1: LOAD after E1, PLAY after E2.
  - New outputs and gen_en=1 are visible after E2.
  - gen_en stays high for exactly note_dur*TICK_DIV cycles of run=1.
- Back-to-back notes: gen_en is low for 2 cycles (DONE, LOAD) between notes.
- run falling in IDLE or DONE: no new note starts; the FIFO retains its contents.

Optional Feature:
WSEQ_GAP_EN:
- Defined: adds state GAP. DONE goes to GAP instead of LOAD/IDLE. GAP counts GAP_TICKS ticks using the prescaler (paused by run=0), with gen_en=0. It then goes to LOAD if fifo_count!=0 && run, else IDLE. flush and rst also abort GAP.
- Undefined: no GAP state, and the GAP_TICKS parameter is ignored.

Test Plan:
All scenarios use TICK_DIV=4 and DEPTH=4.
1. Reset: rst=1 for 2 cycles, then release -> all outputs 0, note_ready=1, busy=0, fifo_count=0.
2. Single note: push freq=0x0100, wave=01, duty=0x0008, dur=3 -> gen_en=1 for exactly 12 cycles, starting 2 cycles after the push edge; outputs 0x0100/01/0x0008; one note_done pulse; then IDLE, busy=0.
3. Full FIFO:
   - run=0; push 5 notes with note_valid held -> 4 accepted; note_ready=0; fifo_count=4.
   - run=1 -> notes play in order with 2-cycle gen_en gaps; the 5th note is accepted on the first pop.
4. Edge cases:
   - dur=0 note between two dur=2 notes -> discarded, with a note_done pulse and no gen_en.
   - wave=11 -> wave_sel_out=00.
5. Pause: run=0 for 10 cycles mid-PLAY -> gen_en=0 and counters frozen; total gen_en-high cycles still equal dur*4.
6. Interrupts:
   - flush mid-PLAY with 2 notes queued -> gen_en=0, fifo_count=0, IDLE at the next edge, no note_done.
   - rst mid-PLAY -> full reset values.
   - With WSEQ_GAP_EN and GAP_TICKS=2: gen_en low for 1+8+1 cycles between consecutive notes.
